// File: rtl/duty_ramp.sv
// duty_ramp: soft-start / soft-stop duty controller for a downstream 256-clock
// PWM stage. The duty cycle moves toward the requested target in STEP
// increments, once every DIV PWM frames. A direction reversal always ramps
// through zero duty first. The estop input kills the drive on the next edge.
module duty_ramp #(
   parameter int unsigned STEP = 1,   // duty change per update, 1..255
   parameter int unsigned DIV  = 4    // PWM frames per duty update, 1..256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic [7:0] target,
   input  logic       dir_req,
   input  logic       estop,
   output logic [7:0] duty,
   output logic       enable,
   output logic       dir,
   output logic       at_target
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RAMP,
      ST_HOLD,
      ST_REVERSE,
      ST_STOP
   } state_t;

   localparam logic [7:0] STEP_B   = 8'(STEP);
   localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

   state_t     state_q, state_d;
   logic [7:0] duty_q, duty_d;
   logic       enable_q, enable_d;
   logic       dir_q, dir_d;
   logic       at_target_q, at_target_d;
   logic [7:0] frame_q, frame_d;
   logic [7:0] div_q, div_d;

   logic       count_en;
   logic       frame_tick;
   logic       strobe;
   logic [7:0] eff_target;
   logic [8:0] up_sum;
   logic [8:0] dn_limit;
   logic [7:0] ramp_val;

   // Frame counter and update divider; both run only across consecutive
   // enabled cycles so the frame count matches the downstream PWM counter,
   // which starts from 0 on the first enabled clock.
   always_comb begin
      count_en   = enable_q && enable_d;
      frame_tick = enable_q && (frame_q == 8'hFF);
      strobe     = frame_tick && (div_q == DIV_LAST);
      frame_d    = count_en ? frame_q + 8'd1 : 8'd0;
      if (!count_en) begin
         div_d = 8'd0;
      end else if (frame_tick) begin
         div_d = strobe ? 8'd0 : div_q + 8'd1;
      end else begin
         div_d = div_q;
      end
   end

   // One ramp step toward the effective target, clamped so it never
   // overshoots the target and never wraps past 0 or 255.
   always_comb begin
      eff_target = ((state_q == ST_REVERSE) || !run) ? 8'd0 : target;
      up_sum     = {1'b0, duty_q} + {1'b0, STEP_B};
      dn_limit   = {1'b0, eff_target} + {1'b0, STEP_B};
      if (duty_q < eff_target) begin
         ramp_val = (up_sum > {1'b0, eff_target}) ? eff_target : up_sum[7:0];
      end else if (duty_q > eff_target) begin
         ramp_val = ({1'b0, duty_q} < dn_limit) ? eff_target : duty_q - STEP_B;
      end else begin
         ramp_val = duty_q;
      end
   end

   // Next-state and next-output logic for the control FSM.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the case
      // leaves it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      duty_d  = duty_q;
      dir_d   = dir_q;

      unique case (state_q)
         ST_IDLE: begin
            duty_d = 8'd0;
            dir_d  = dir_req;
            if (run && !estop) begin
               state_d = ST_RAMP;
            end
         end

         ST_RAMP: begin
            if (strobe) begin
               duty_d = ramp_val;
            end
            if (dir_req != dir_q) begin
               state_d = ST_REVERSE;
            end else if (run && (duty_q == eff_target)) begin
               state_d = ST_HOLD;
            end else if (!run && (duty_q == 8'd0)) begin
               state_d = ST_IDLE;
            end
         end

         ST_HOLD: begin
            if (dir_req != dir_q) begin
               state_d = ST_REVERSE;
            end else if (!run || (target != duty_q)) begin
               state_d = ST_RAMP;
            end
         end

         ST_REVERSE: begin
            // Direction is only ever swapped once the drive is at zero duty.
            if (duty_q == 8'd0) begin
               dir_d   = dir_req;
               state_d = run ? ST_RAMP : ST_IDLE;
            end else if (strobe) begin
               duty_d = ramp_val;
            end
         end

         ST_STOP: begin
            duty_d = 8'd0;
            if (!estop && !run) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            duty_d  = 8'd0;
         end
      endcase

      // Emergency stop overrides every state and kills the drive on the next edge.
      if (estop) begin
         state_d = ST_STOP;
         duty_d  = 8'd0;
         dir_d   = dir_q;
      end

      enable_d    = (state_d == ST_RAMP) || (state_d == ST_HOLD) ||
                    (state_d == ST_REVERSE);
      at_target_d = (state_d == ST_HOLD);
   end

   // State and output registers; reset forces a safe, fully idle drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         duty_q      <= 8'd0;
         enable_q    <= 1'b0;
         dir_q       <= 1'b0;
         at_target_q <= 1'b0;
         frame_q     <= 8'd0;
         div_q       <= 8'd0;
      end else begin
         // NOTE: non-blocking assignments so every register samples values
         // from before the edge, independent of statement order.
         state_q     <= state_d;
         duty_q      <= duty_d;
         enable_q    <= enable_d;
         dir_q       <= dir_d;
         at_target_q <= at_target_d;
         frame_q     <= frame_d;
         div_q       <= div_d;
      end
   end

   assign duty      = duty_q;
   assign enable    = enable_q;
   assign dir       = dir_q;
   assign at_target = at_target_q;

endmodule

// File: tb/tb_duty_ramp.sv
// tb_duty_ramp: directed bench for duty_ramp with STEP=16. dut uses DIV=1,
// dut4 uses DIV=4; both share the same inputs. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_duty_ramp;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run;
   logic [7:0] target;
   logic       dir_req;
   logic       estop;

   logic [7:0] duty, duty4;
   logic       enable, enable4;
   logic       dir, dir4;
   logic       at_target, at_target4;

   int checks   = 0;
   int failures = 0;
   int n;
   logic dir_prev = 1'b0;

   always #5 clk = ~clk;

   duty_ramp #(.STEP(16), .DIV(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .target    (target),
      .dir_req   (dir_req),
      .estop     (estop),
      .duty      (duty),
      .enable    (enable),
      .dir       (dir),
      .at_target (at_target)
   );

   duty_ramp #(.STEP(16), .DIV(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .target    (target),
      .dir_req   (dir_req),
      .estop     (estop),
      .duty      (duty4),
      .enable    (enable4),
      .dir       (dir4),
      .at_target (at_target4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   // Wait (bounded) until dut duty reaches exp; an expired budget shows up as a failed check.
   task automatic wait_duty(input string tag, input logic [7:0] exp, input int budget,
                            output int waited);
      waited = 0;
      while ((duty !== exp) && (waited < budget)) begin
         @(negedge clk);
         waited++;
      end
      check(tag, duty, exp);
   endtask

   // Direction must only ever change while duty is zero.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && dir !== dir_prev) begin
         check("dir_change_at_zero_duty", duty, 8'h00);
      end
      dir_prev = dir;
   end

   initial begin
      rst_n   = 1'b0;
      run     = 1'b0;
      target  = 8'h00;
      dir_req = 1'b0;
      estop   = 1'b0;
      tick(2);

      // Reset state
      check("rst_duty", duty, 8'h00);
      check("rst_enable", enable, 1'b0);
      check("rst_dir", dir, 1'b0);
      check("rst_at_target", at_target, 1'b0);

      // Ramp up 0 -> 0x40 in 0x10 steps, one per 256-clock frame
      rst_n  = 1'b1;
      run    = 1'b1;
      target = 8'h40;
      tick(1);
      check("start_enable", enable, 1'b1);
      check("start_duty", duty, 8'h00);
      check("start_frame", dut.frame_q, 8'h00);
      for (int k = 1; k <= 4; k++) begin
         tick(255);
         check("ramp_before_strobe", duty, 8'(16 * (k - 1)));
         tick(1);
         check("ramp_after_strobe", duty, 8'(16 * k));
      end
      check("ramp_at_target_pending", at_target, 1'b0);
      tick(1);
      check("hold_at_target", at_target, 1'b1);
      check("hold_enable", enable, 1'b1);

      // Clamped step 0x40 -> 0x45 on the existing frame grid
      target = 8'h45;
      tick(1);
      check("retarget_leaves_hold", at_target, 1'b0);
      tick(253);
      check("retarget_before_strobe", duty, 8'h40);
      tick(1);
      check("retarget_clamped", duty, 8'h45);
      tick(1);
      check("retarget_hold", at_target, 1'b1);

      // Top-end clamp: 0xF5 -> 0xFF without wrapping
      target = 8'hF5;
      wait_duty("reach_f5", 8'hF5, 3000, n);
      tick(1);
      check("hold_f5", at_target, 1'b1);
      target = 8'hFF;
      wait_duty("reach_ff", 8'hFF, 300, n);
      check("reach_ff_latency", n, 255);
      tick(1);
      check("hold_ff", at_target, 1'b1);
      tick(300);
      check("ff_no_wrap", duty, 8'hFF);

      // Ramp down to 0x30, then reverse through zero
      target = 8'h30;
      wait_duty("reach_30", 8'h30, 3500, n);
      tick(1);
      check("hold_30", at_target, 1'b1);
      dir_req = 1'b1;
      tick(1);
      check("reverse_leaves_hold", at_target, 1'b0);
      wait_duty("rev_20", 8'h20, 300, n);
      check("rev_20_dir", dir, 1'b0);
      wait_duty("rev_10", 8'h10, 300, n);
      check("rev_step_interval", n, 256);
      wait_duty("rev_00", 8'h00, 300, n);
      check("rev_00_dir_old", dir, 1'b0);
      check("rev_00_enable", enable, 1'b1);
      tick(1);
      check("rev_dir_new", dir, 1'b1);
      check("rev_enable_kept", enable, 1'b1);
      wait_duty("fwd_10", 8'h10, 300, n);
      wait_duty("fwd_20", 8'h20, 300, n);
      wait_duty("fwd_30", 8'h30, 300, n);
      tick(1);
      check("fwd_hold", at_target, 1'b1);
      check("fwd_dir", dir, 1'b1);

      // run=0 from HOLD at 0x20 ramps to zero and idles
      target = 8'h20;
      wait_duty("reach_20", 8'h20, 300, n);
      tick(1);
      check("hold_20", at_target, 1'b1);
      run = 1'b0;
      wait_duty("stop_10", 8'h10, 300, n);
      wait_duty("stop_00", 8'h00, 300, n);
      check("stop_00_enable", enable, 1'b1);
      tick(1);
      check("idle_enable", enable, 1'b0);
      check("idle_frame", dut.frame_q, 8'h00);
      tick(4);
      check("idle_frame_held", dut.frame_q, 8'h00);
      dir_req = 1'b0;
      tick(1);
      check("idle_dir_follows", dir, 1'b0);

      // Emergency stop mid-ramp
      run    = 1'b1;
      target = 8'h40;
      tick(1);
      check("estop_pre_enable", enable, 1'b1);
      wait_duty("estop_pre_10", 8'h10, 300, n);
      tick(100);
      estop = 1'b1;
      tick(1);
      check("estop_duty", duty, 8'h00);
      check("estop_enable", enable, 1'b0);
      check("estop_at_target", at_target, 1'b0);
      estop   = 1'b0;
      dir_req = 1'b1;
      tick(3);
      check("stop_held_enable", enable, 1'b0);
      check("stop_held_dir", dir, 1'b0);
      run = 1'b0;
      tick(1);
      check("stop_exit_dir", dir, 1'b0);
      tick(1);
      check("idle_after_stop_dir", dir, 1'b1);
      dir_req = 1'b0;
      tick(1);
      check("idle_after_stop_dir0", dir, 1'b0);
      check("idle_after_stop_enable", enable, 1'b0);

      // DIV=4: one update per 1024 clocks, async reset mid-ramp
      rst_n = 1'b0;
      #1;
      check("div4_rst_duty", duty4, 8'h00);
      @(negedge clk);
      rst_n  = 1'b1;
      run    = 1'b1;
      target = 8'h40;
      tick(1);
      check("div4_start_enable", enable4, 1'b1);
      tick(1023);
      check("div4_before_strobe", duty4, 8'h00);
      tick(1);
      check("div4_first_step", duty4, 8'h10);
      tick(500);
      check("div1_mid_ramp_duty", duty, 8'h40);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_duty4", duty4, 8'h00);
      check("async_rst_enable4", enable4, 1'b0);
      check("async_rst_dir4", dir4, 1'b0);
      check("async_rst_at_target4", at_target4, 1'b0);
      check("async_rst_frame4", dut4.frame_q, 8'h00);
      check("async_rst_div4", dut4.div_q, 8'h00);
      check("async_rst_duty1", duty, 8'h00);
      check("async_rst_enable1", enable, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
      check("div4_restart_enable", enable4, 1'b1);
      check("div4_restart_duty", duty4, 8'h00);
      tick(1023);
      check("div4_restart_before", duty4, 8'h00);
      tick(1);
      check("div4_restart_step", duty4, 8'h10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
